// File: rtl/sdram_pkg.sv
// Shared SDRAM constants and helpers used by the controller, arbiter and pattern engine.
package sdram_pkg;

  localparam int SDRAM_AW = 23;
  localparam int SDRAM_DW = 32;

  // Requester-id width; a single bit is kept even for one or two requesters.
  function automatic int req_id_w(input int num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Synchronous tag FIFO remembering which requester owns each in-flight read.
module sdram_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push != do_pop)
        count <= do_push ? count + CW'(1) : count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port between NUM_REQ requesters;
// read data is routed back in issue order through a tag FIFO.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*SDRAM_AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [NUM_REQ*SDRAM_DW-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]          req_in_valid,
  output logic [NUM_REQ-1:0]          req_busy,
  output logic [SDRAM_DW-1:0]         req_data_out,
  output logic [NUM_REQ-1:0]          req_out_valid,
  output logic [SDRAM_AW-1:0]         sd_addr,
  output logic                        sd_rw,
  output logic [SDRAM_DW-1:0]         sd_data_in,
  output logic                        sd_in_valid,
  input  logic                        sd_busy,
  input  logic [SDRAM_DW-1:0]         sd_data_out,
  input  logic                        sd_out_valid,
  output logic                        rd_err
);

  localparam int IDW = req_id_w(NUM_REQ);

  logic [IDW-1:0] gp;
  logic [IDW-1:0] gp_next;
  logic [IDW-1:0] head;
  logic           tag_full;
  logic           tag_empty;
  logic           owner_valid;
  logic           accept;
  logic           advance;
  logic           push;
  logic           pop;

  // Busy is deliberately conservative: writes are also held off while the tag FIFO is full.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      req_busy[i] = rst | sd_busy | tag_full | (gp != IDW'(i));
  end

  always_comb begin
    sd_addr     = '0;
    sd_rw       = 1'b0;
    sd_data_in  = '0;
    owner_valid = 1'b0;
    accept      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gp == IDW'(i)) begin
        sd_addr     = req_addr[i*SDRAM_AW +: SDRAM_AW];
        sd_rw       = req_rw[i];
        sd_data_in  = req_data_in[i*SDRAM_DW +: SDRAM_DW];
        owner_valid = req_in_valid[i];
        accept      = req_in_valid[i] & ~req_busy[i];
      end
    end
  end

  assign sd_in_valid = accept;
  assign gp_next     = (gp == IDW'(NUM_REQ - 1)) ? '0 : gp + IDW'(1);
  assign advance     = accept | (~sd_busy & ~tag_full & ~owner_valid);
  assign push        = accept & ~sd_rw;
  assign pop         = sd_out_valid & ~tag_empty;

  // An idle owner yields its slot so no requester waits more than NUM_REQ-1 free slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gp     <= '0;
      rd_err <= 1'b0;
    end else begin
      if (advance) gp <= gp_next;
      if (sd_out_valid & tag_empty) rd_err <= 1'b1;
    end
  end

  sdram_tag_fifo #(
    .WIDTH (IDW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (gp),
    .pop       (pop),
    .head      (head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  assign req_data_out = sd_data_out;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      req_out_valid[i] = pop & (head == IDW'(i));
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: command-path vector table plus a latency-modelled
// controller with an in-order read-return scoreboard.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int NUM_REQ   = 2;
  localparam int TAG_DEPTH = 4;

  localparam logic [SDRAM_AW-1:0] ADDR0 = 23'h000010;
  localparam logic [SDRAM_AW-1:0] ADDR1 = 23'h000200;
  localparam logic [SDRAM_DW-1:0] DATA0 = 32'hDEADBEEF;
  localparam logic [SDRAM_DW-1:0] DATA1 = 32'h12345678;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_REQ*SDRAM_AW-1:0] req_addr;
  logic [NUM_REQ-1:0]          req_rw;
  logic [NUM_REQ*SDRAM_DW-1:0] req_data_in;
  logic [NUM_REQ-1:0]          req_in_valid;
  logic [NUM_REQ-1:0]          req_busy;
  logic [SDRAM_DW-1:0]         req_data_out;
  logic [NUM_REQ-1:0]          req_out_valid;
  logic [SDRAM_AW-1:0]         sd_addr;
  logic                        sd_rw;
  logic [SDRAM_DW-1:0]         sd_data_in;
  logic                        sd_in_valid;
  logic                        sd_busy;
  logic [SDRAM_DW-1:0]         sd_data_out = '0;
  logic                        sd_out_valid = 1'b0;
  logic                        rd_err;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_addr      (req_addr),
    .req_rw        (req_rw),
    .req_data_in   (req_data_in),
    .req_in_valid  (req_in_valid),
    .req_busy      (req_busy),
    .req_data_out  (req_data_out),
    .req_out_valid (req_out_valid),
    .sd_addr       (sd_addr),
    .sd_rw         (sd_rw),
    .sd_data_in    (sd_data_in),
    .sd_in_valid   (sd_in_valid),
    .sd_busy       (sd_busy),
    .sd_data_out   (sd_data_out),
    .sd_out_valid  (sd_out_valid),
    .rd_err        (rd_err)
  );

  typedef struct {
    logic [1:0]          in_valid;
    logic [1:0]          rw;
    logic                sd_busy;
    logic [1:0]          exp_busy;
    logic                exp_in_valid;
    logic                exp_rw;
    logic [SDRAM_AW-1:0] exp_addr;
    logic [SDRAM_DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    int                  due;
    logic [SDRAM_DW-1:0] data;
  } ret_t;

  typedef struct {
    logic [1:0]          strobe;
    logic [SDRAM_DW-1:0] data;
  } exp_t;

  vec_t                vecs [11];
  ret_t                pend_q [$];
  exp_t                exp_q [$];
  logic [SDRAM_AW-1:0] q0 [$];
  logic [SDRAM_AW-1:0] q1 [$];

  int                  vec_count    = 0;
  int                  miscompares  = 0;
  int                  all_busy_cnt = 0;
  int                  lat          = 10;
  int                  cyc          = 0;
  int                  inject_req   = 0;
  int                  inject_done  = 0;
  logic                cap_valid;
  logic [SDRAM_AW-1:0] cap_addr;

  function automatic logic [SDRAM_DW-1:0] rdPattern(input logic [SDRAM_AW-1:0] a);
    return 32'hC0DE0000 ^ {9'd0, a};
  endfunction

  // Controller model: fixed read latency, in-order returns, optional stray return injection.
  always begin
    @(negedge clk);
    cap_valid = sd_in_valid && !sd_rw;
    cap_addr  = sd_addr;
    @(posedge clk);
    cyc++;
    if (cap_valid) pend_q.push_back('{cyc + lat, rdPattern(cap_addr)});
    #1;
    sd_out_valid = 1'b0;
    sd_data_out  = '0;
    if (inject_req != inject_done) begin
      inject_done++;
      sd_out_valid = 1'b1;
      sd_data_out  = 32'hBAD00BAD;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      sd_out_valid = 1'b1;
      sd_data_out  = pend_q[0].data;
      void'(pend_q.pop_front());
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    req_in_valid = v.in_valid;
    req_rw       = v.rw;
    sd_busy      = v.sd_busy;
    @(negedge clk);
    checkOutput($sformatf("vec%0d busy", idx), 64'(req_busy), 64'(v.exp_busy));
    checkOutput($sformatf("vec%0d sd_in_valid", idx), 64'(sd_in_valid), 64'(v.exp_in_valid));
    if (v.exp_in_valid) begin
      checkOutput($sformatf("vec%0d sd_rw", idx), 64'(sd_rw), 64'(v.exp_rw));
      checkOutput($sformatf("vec%0d sd_addr", idx), 64'(sd_addr), 64'(v.exp_addr));
      checkOutput($sformatf("vec%0d sd_data_in", idx), 64'(sd_data_in), 64'(v.exp_data));
    end
    @(posedge clk);
    #1;
  endtask

  // One clock of traffic: sample at negedge, compare any return against the scoreboard head.
  task automatic step(output logic [1:0] acc, output logic [1:0] busy, output logic ret);
    exp_t e;
    @(negedge clk);
    acc  = req_in_valid & ~req_busy;
    busy = req_busy;
    ret  = (req_out_valid != '0);
    if (busy === 2'b11) all_busy_cnt++;
    if (ret) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected strobe", 64'(req_out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("return strobe", 64'(req_out_valid), 64'(e.strobe));
        checkOutput("return data", 64'(req_data_out), 64'(e.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic driveReqs();
    req_in_valid = '0;
    req_rw       = '0;
    if (q0.size() > 0) begin
      req_in_valid[0]            = 1'b1;
      req_addr[0 +: SDRAM_AW]    = q0[0];
    end
    if (q1.size() > 0) begin
      req_in_valid[1]             = 1'b1;
      req_addr[SDRAM_AW +: SDRAM_AW] = q1[0];
    end
  endtask

  task automatic popAccepted(input logic [1:0] acc);
    if (acc[0] && q0.size() > 0) void'(q0.pop_front());
    if (acc[1] && q1.size() > 0) void'(q1.pop_front());
  endtask

  task automatic runTraffic(input string name, input int budget);
    logic [1:0] acc;
    logic [1:0] busy;
    logic       ret;
    int         n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < budget) begin
      driveReqs();
      step(acc, busy, ret);
      popAccepted(acc);
      n++;
    end
    req_in_valid = '0;
    checkOutput({name, " drained"}, 64'(q0.size() + q1.size() + exp_q.size()), 64'd0);
  endtask

  task automatic doReset();
    rst          = 1'b1;
    req_in_valid = 2'b11;
    req_rw       = 2'b00;
    sd_busy      = 1'b0;
    #1;
    checkOutput("reset busy", 64'(req_busy), 64'(2'b11));
    checkOutput("reset sd_in_valid", 64'(sd_in_valid), 64'd0);
    checkOutput("reset out_valid", 64'(req_out_valid), 64'd0);
    checkOutput("reset rd_err", 64'(rd_err), 64'd0);
    exp_q.delete();
    q0.delete();
    q1.delete();
    @(negedge clk);
    req_in_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] acc;
    logic [1:0] busy;
    logic       ret;
    int         acc_cnt;
    int         acc_at_ret;
    int         first_ret;
    int         fifth;
    int         busy_bad;
    int         n;

    vecs[0]  = '{2'b01, 2'b01, 1'b0, 2'b10, 1'b1, 1'b1, ADDR0, DATA0};
    vecs[1]  = '{2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, '0, '0};
    vecs[2]  = '{2'b10, 2'b10, 1'b0, 2'b10, 1'b0, 1'b0, '0, '0};
    vecs[3]  = '{2'b10, 2'b10, 1'b1, 2'b11, 1'b0, 1'b0, '0, '0};
    vecs[4]  = '{2'b10, 2'b10, 1'b0, 2'b01, 1'b1, 1'b1, ADDR1, DATA1};
    vecs[5]  = '{2'b01, 2'b01, 1'b1, 2'b11, 1'b0, 1'b0, '0, '0};
    vecs[6]  = '{2'b01, 2'b01, 1'b0, 2'b10, 1'b1, 1'b1, ADDR0, DATA0};
    vecs[7]  = '{2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0, '0, '0};
    vecs[8]  = '{2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, '0, '0};
    vecs[9]  = '{2'b11, 2'b11, 1'b0, 2'b10, 1'b1, 1'b1, ADDR0, DATA0};
    vecs[10] = '{2'b11, 2'b11, 1'b0, 2'b01, 1'b1, 1'b1, ADDR1, DATA1};

    req_addr    = {ADDR1, ADDR0};
    req_data_in = {DATA1, DATA0};
    req_rw      = '0;
    doReset();

    // Write-only command path and grant rotation.
    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);
    req_in_valid = '0;
    sd_busy      = 1'b0;

    // Stray return: the writes above must not have left any tag behind.
    inject_req++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sd_out_valid && n < 5);
    checkOutput("inject seen", 64'(sd_out_valid), 64'd1);
    checkOutput("inject strobe", 64'(req_out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rd_err set", 64'(rd_err), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rd_err sticky", 64'(rd_err), 64'd1);
    doReset();

    // Two requesters with pending reads alternate 0,1,0,1.
    lat = 10;
    q0.push_back(23'h000100);
    q0.push_back(23'h000101);
    q1.push_back(23'h000200);
    q1.push_back(23'h000201);
    exp_q.push_back('{2'b01, rdPattern(23'h000100)});
    exp_q.push_back('{2'b10, rdPattern(23'h000200)});
    exp_q.push_back('{2'b01, rdPattern(23'h000101)});
    exp_q.push_back('{2'b10, rdPattern(23'h000201)});
    runTraffic("alternate", 80);

    // Five back-to-back reads from req0 against a full tag FIFO.
    doReset();
    lat = 10;
    for (int k = 0; k < 5; k++) begin
      q0.push_back(23'h000300 + 23'(k));
      exp_q.push_back('{2'b01, rdPattern(23'h000300 + 23'(k))});
    end
    acc_cnt    = 0;
    acc_at_ret = -1;
    first_ret  = -1;
    fifth      = -1;
    busy_bad   = 0;
    n          = 0;
    while ((q0.size() > 0 || exp_q.size() > 0) && n < 80) begin
      driveReqs();
      step(acc, busy, ret);
      if (acc_cnt == 4 && first_ret < 0 && busy !== 2'b11) busy_bad++;
      if (ret && first_ret < 0) begin
        first_ret  = n;
        acc_at_ret = acc_cnt;
      end
      if (acc[0]) begin
        acc_cnt++;
        if (acc_cnt == 5) fifth = n;
      end
      popAccepted(acc);
      n++;
    end
    req_in_valid = '0;
    checkOutput("burst drained", 64'(q0.size() + exp_q.size()), 64'd0);
    checkOutput("reads before first return", 64'(acc_at_ret), 64'd4);
    checkOutput("busy while full", 64'(busy_bad), 64'd0);
    checkOutput("fifth issue after pop", 64'((fifth - first_ret >= 1) && (fifth - first_ret <= NUM_REQ)), 64'd1);

    // Latency 1 keeps two reads in flight so push and pop coincide every cycle.
    doReset();
    lat          = 1;
    all_busy_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      q0.push_back(23'h000400 + 23'(k));
      q1.push_back(23'h000500 + 23'(k));
      exp_q.push_back('{2'b01, rdPattern(23'h000400 + 23'(k))});
      exp_q.push_back('{2'b10, rdPattern(23'h000500 + 23'(k))});
    end
    runTraffic("push-pop", 40);
    checkOutput("never full at count 2", 64'(all_busy_cnt), 64'd0);

    // Asynchronous reset with reads in flight: tags discarded, late returns flag rd_err.
    doReset();
    lat = 10;
    q0.push_back(23'h000600);
    q1.push_back(23'h000700);
    q0.push_back(23'h000601);
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 10) begin
      driveReqs();
      step(acc, busy, ret);
      popAccepted(acc);
      n++;
    end
    req_in_valid = '0;
    #1;
    checkOutput("gp before rst", 64'(req_busy), 64'(2'b01));
    rst = 1'b1;
    #1;
    checkOutput("mid-cycle rst busy", 64'(req_busy), 64'(2'b11));
    rst = 1'b0;
    #1;
    checkOutput("gp cleared async", 64'(req_busy), 64'(2'b10));
    checkOutput("rd_err cleared", 64'(rd_err), 64'd0);
    for (int k = 0; k < 20; k++) step(acc, busy, ret);
    checkOutput("late return rd_err", 64'(rd_err), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares one sdram controller command port (addr/rw/data_in/in_valid/busy, read return data_out/out_valid) between NUM_REQ requesters, e.g. MicroBlaze MCS IO bridge and the ram_test pattern engine.
- Round-robin grant, combinational command mux.
- Tag FIFO records which requester owns each in-flight read, so read data is routed back in order.
- Sits between the requesters and sdram; each requester sees an interface identical to the sdram controller's.

Parameters:
- NUM_REQ, 2, number of requesters (2..4); requester index i occupies slice i of each flattened bus.
- TAG_DEPTH, 4, in-flight read tag FIFO depth (power of two).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_addr  in  NUM_REQ*23  per-requester word address.
- req_rw  in  NUM_REQ  per-requester direction; 1 = write, 0 = read.
- req_data_in  in  NUM_REQ*32  per-requester write data.
- req_in_valid  in  NUM_REQ  command strobe; legal only in a cycle where that requester's req_busy is low.
- req_busy  out  NUM_REQ  per-requester busy.
- req_data_out  out  32  read data, broadcast to all requesters.
- req_out_valid  out  NUM_REQ  one-hot read-data strobe.
- sd_addr  out  23  to controller addr.
- sd_rw  out  1  to controller rw.
- sd_data_in  out  32  to controller data_in.
- sd_in_valid  out  1  to controller in_valid.
- sd_busy  in  1  from controller busy.
- sd_data_out  in  32  from controller data_out.
- sd_out_valid  in  1  from controller out_valid.
- rd_err  out  1  sticky: sd_out_valid arrived with the tag FIFO empty.

Behaviour:
- Reset (async, rst=1): grant pointer gp=0, tag FIFO empty (count=0, rd/wr ptr=0), rd_err=0. req_busy is all-ones while rst is high. sd_in_valid=0 and req_out_valid=0.
- Resetting mid-transaction discards all tags; read data the controller returns afterwards sets rd_err. The system resets the controller together with the arbiter.
- Busy:
  - req_busy[i] = rst | sd_busy | tag_full | (gp != i).
  - Combinational; a requester sees busy low only while it holds the grant.
  - Busy is conservative: writes are also blocked while tag_full.
- Command path, all combinational with 0-cycle latency:
  - accept = req_in_valid[gp] & ~req_busy[gp].
  - sd_in_valid = accept.
  - sd_addr, sd_rw and sd_data_in are muxed from slice gp.
  - In-valid from a non-granted requester is a protocol violation and is ignored.
- Grant pointer update, registered on each rising edge:
  - If accept: gp <= (gp+1) mod NUM_REQ.
  - Else if ~sd_busy & ~tag_full & ~req_in_valid[gp]: gp advances the same way; an idle owner yields.
  - Else gp holds.
  - Worst-case wait for any requester is NUM_REQ-1 free command slots.
- Tag FIFO:
  - Push gp when accept & ~sd_rw.
  - Pop when sd_out_valid & ~empty.
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
  - Pointers wrap modulo TAG_DEPTH.
  - count is $clog2(TAG_DEPTH)+1 bits; full = (count==TAG_DEPTH), empty = (count==0).
- Read return, combinational:
  - req_data_out = sd_data_out.
  - req_out_valid = onehot(head tag) when sd_out_valid & ~empty, else 0.
  - sd_out_valid with empty FIFO: no strobe, and rd_err <= 1 until reset.
- Writes produce no response and no tag.

Decomposition:
- Shared package sdram_pkg holds SDRAM_AW=23, SDRAM_DW=32 and a REQ_ID width function ($clog2(NUM_REQ), minimum 1), also used by sdram and ram_test.
- One sub-module, sdram_tag_fifo: sync FIFO with count, full/empty and simultaneous push/pop, WIDTH=REQ_ID width, DEPTH=TAG_DEPTH.
- The grant and mux logic stays in sdram_arbiter.

Test Plan:
- Reset, then req0 writes addr 0x000010 data 0xDEADBEEF -> sd_in_valid pulses 1 cycle with that addr/data and sd_rw=1; gp becomes 1; no tag pushed.
- Both requesters hold a pending read (req0 addr 0x000100, req1 addr 0x000200) -> commands issue alternately 0,1,0,1. Returned data is strobed on req_out_valid=01, then 10, in issue order.
- Controller model with 10-cycle read latency; req0 issues 5 back-to-back reads -> after 4 reads, req_busy=all-ones until the first return. The 5th read issues the cycle after the first pop; count never exceeds 4.
- Push and pop in the same cycle at count=2 -> count stays 2 and the tag order is preserved (check req_out_valid sequence).
- Inject sd_out_valid with no reads outstanding -> req_out_valid=0 and rd_err=1. rd_err stays 1 until rst; rst mid-burst clears the FIFO and gp=0 asynchronously.
- Full system with sdram + mt48lc32m8a2 + ram_test on port 0 and an idle port 1 -> ram_test completes two write/read passes with read errors = 0x00.
